// File: rtl/regfile_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_sb_if
// Bundles the read, writeback, issue and clear signals of regfile_sb.
//   master : the core side (decode/writeback/hazard logic) drives addresses,
//            write data, issue and clear; it receives read data, pending
//            flags and clear_busy.
//   slave  : the register file itself.
// Parameters must match those of the regfile_sb instance it connects to.
// ---------------------------------------------------------------------------
interface regfile_sb_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [ADDR_W-1:0] i_rs1_addr;
  logic [ADDR_W-1:0] i_rs2_addr;
  logic [DATA_W-1:0] o_rs1_data;
  logic [DATA_W-1:0] o_rs2_data;
  logic              i_rd_wren;
  logic [ADDR_W-1:0] i_rd_addr;
  logic [DATA_W-1:0] i_rd_data;
  logic              i_issue_en;
  logic [ADDR_W-1:0] i_issue_addr;
  logic              o_rs1_pending;
  logic              o_rs2_pending;
  logic              i_clear;
  logic              o_clear_busy;

  modport master (
    output i_rs1_addr, i_rs2_addr, i_rd_wren, i_rd_addr, i_rd_data,
           i_issue_en, i_issue_addr, i_clear,
    input  o_rs1_data, o_rs2_data, o_rs1_pending, o_rs2_pending, o_clear_busy
  );

  modport slave (
    input  i_rs1_addr, i_rs2_addr, i_rd_wren, i_rd_addr, i_rd_data,
           i_issue_en, i_issue_addr, i_clear,
    output o_rs1_data, o_rs2_data, o_rs1_pending, o_rs2_pending, o_clear_busy
  );
endinterface

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Register file with two combinational read ports, one write port, optional
// write-to-read bypass, optional hardwired zero register, a per-register
// pending (scoreboard) bit and a sequential clear engine that zeroes one
// entry per cycle.
// Ports:
//   i_clk   : clock, all state updates on the rising edge
//   i_reset : asynchronous active-high reset; zeroes array, pending bits,
//             returns the clear engine to idle
//   bus     : regfile_sb_if.slave (read/write/issue/clear signals)
// The array is held in flops: the asynchronous reset must zero every entry
// at once, which a RAM macro cannot do.
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  regfile_sb_if.slave  bus
);
  localparam int              ADDR_W   = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic            BYP_EN   = (BYPASS != 0);
  localparam logic            ZR_EN    = (ZERO_REG != 0);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;

  logic clear_busy;
  logic wr_ok;
  logic iss_ok;
  logic fwd1, fwd2;

  assign clear_busy       = (state_q == ST_CLEAR);
  assign bus.o_clear_busy = clear_busy;

  // Writes and issues are simply dropped while the clear engine runs.
  assign wr_ok  = bus.i_rd_wren & ~clear_busy
                & ~(ZR_EN & (bus.i_rd_addr == '0));
  assign iss_ok = bus.i_issue_en & ~clear_busy
                & ~(ZR_EN & (bus.i_issue_addr == '0));

  // ---------------- clear engine FSM ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        // i_clear is ignored here: a running clear is never restarted.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------- array and scoreboard next state ----------------
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    pend_d = pend_q;

    if (wr_ok) begin
      regs_d[bus.i_rd_addr] = bus.i_rd_data;
      pend_d[bus.i_rd_addr] = 1'b0;
    end
    // Applied after the writeback clear so a new producer issued on the
    // same edge as the old one's writeback keeps the register pending.
    if (iss_ok) begin
      pend_d[bus.i_issue_addr] = 1'b1;
    end
    if (clear_busy) begin
      regs_d[cnt_q] = '0;
      pend_d[cnt_q] = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // ---------------- read ports ----------------
  // Forwarding uses wr_ok, so it is automatically off during clear and for
  // the zero register.
  assign fwd1 = BYP_EN & wr_ok & (bus.i_rd_addr == bus.i_rs1_addr);
  assign fwd2 = BYP_EN & wr_ok & (bus.i_rd_addr == bus.i_rs2_addr);

  always_comb begin
    if (fwd1) begin
      bus.o_rs1_data = bus.i_rd_data;
    end else if (ZR_EN && (bus.i_rs1_addr == '0)) begin
      bus.o_rs1_data = '0;
    end else begin
      bus.o_rs1_data = regs_q[bus.i_rs1_addr];
    end
  end

  always_comb begin
    if (fwd2) begin
      bus.o_rs2_data = bus.i_rd_data;
    end else if (ZR_EN && (bus.i_rs2_addr == '0)) begin
      bus.o_rs2_data = '0;
    end else begin
      bus.o_rs2_data = regs_q[bus.i_rs2_addr];
    end
  end

  // A forwarded operand is no longer waiting on its producer.
  assign bus.o_rs1_pending = pend_q[bus.i_rs1_addr] & ~fwd1
                           & ~(ZR_EN & (bus.i_rs1_addr == '0));
  assign bus.o_rs2_pending = pend_q[bus.i_rs2_addr] & ~fwd2
                           & ~(ZR_EN & (bus.i_rs2_addr == '0));

endmodule
